// File: rtl/decode_stage_hs_if.sv
// Handshake bundle around decode_stage_hs: fetch (D), execute (E) and write-back (W) signals.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface decode_stage_hs_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned REG_SIZE    = 5,
    parameter int unsigned STALL_CNT_W = 32
);
    logic                   validD;
    logic [XLEN-1:0]        pcD;
    logic [XLEN-1:0]        instrD;
    logic                   readyD;
    logic                   flush;

    logic                   regWriteW;
    logic [REG_SIZE-1:0]    writeRegW;
    logic [XLEN-1:0]        resultW;

    logic                   validE;
    logic                   readyE;
    logic [XLEN-1:0]        rdata1E;
    logic [XLEN-1:0]        rdata2E;
    logic [XLEN-1:0]        immE;
    logic [XLEN-1:0]        pcE;
    logic [REG_SIZE-1:0]    writeRegE;
    logic [3:0]             ALUControlE;
    logic [1:0]             ALUSrcE;
    logic                   regWriteE;
    logic                   memWriteE;
    logic                   mem2regE;
    logic                   branchE;
    logic [STALL_CNT_W-1:0] stallCount;

    modport slave (
        input  validD, pcD, instrD, flush, regWriteW, writeRegW, resultW, readyE,
        output readyD, validE, rdata1E, rdata2E, immE, pcE, writeRegE, ALUControlE, ALUSrcE,
               regWriteE, memWriteE, mem2regE, branchE, stallCount
    );

    modport master (
        output validD, pcD, instrD, flush, regWriteW, writeRegW, resultW, readyE,
        input  readyD, validE, rdata1E, rdata2E, immE, pcE, writeRegE, ALUControlE, ALUSrcE,
               regWriteE, memWriteE, mem2regE, branchE, stallCount
    );
endinterface

// File: rtl/decode_stage_hs.sv
// RV32I-subset decode stage: decoder, bypassed register file, pending-write scoreboard and a
// valid/ready decode->execute register with flush and a saturating hazard-stall counter.
module decode_stage_hs #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned REG_COUNT   = 32,
    parameter int unsigned REG_SIZE    = 5,
    parameter int unsigned PEND_W      = 2,
    parameter int unsigned STALL_CNT_W = 32
) (
    input logic               clk,
    input logic               reset,
    decode_stage_hs_if.slave  bus
);
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] ALU_SRC_RD2  = 2'd0;
    localparam logic [1:0] ALU_SRC_IMM  = 2'd1;
    localparam logic [1:0] ALU_SRC_FOUR = 2'd2;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    // ---------------------------------------------------------------- decode
    logic [XLEN-1:0]     instr;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                alt;
    logic [REG_SIZE-1:0] rs1, rs2, rd;

    assign instr  = bus.instrD;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign alt    = instr[30];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic sub_ok,
                                             input logic f7_alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (sub_ok && f7_alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7_alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic            reg_write_dec, mem_write_dec, mem2reg_dec, branch_dec;
    logic            uses_rs1, uses_rs2;
    logic [3:0]      alu_ctrl_dec;
    logic [1:0]      alu_src_dec;
    logic [XLEN-1:0] imm_dec;

    always_comb begin
        reg_write_dec = 1'b0;
        mem_write_dec = 1'b0;
        mem2reg_dec   = 1'b0;
        branch_dec    = 1'b0;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        alu_ctrl_dec  = ALU_ADD;
        alu_src_dec   = ALU_SRC_RD2;
        imm_dec       = '0;
        case (opcode)
            OPCODE_OP: begin
                reg_write_dec = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                alu_ctrl_dec  = alu_arith(funct3, 1'b1, alt);
            end
            OPCODE_OP_IMM: begin
                reg_write_dec = 1'b1;
                uses_rs1      = 1'b1;
                alu_ctrl_dec  = alu_arith(funct3, 1'b0, alt);
                alu_src_dec   = ALU_SRC_IMM;
                imm_dec       = imm_i;
            end
            OPCODE_LOAD: begin
                reg_write_dec = 1'b1;
                mem2reg_dec   = 1'b1;
                uses_rs1      = 1'b1;
                alu_src_dec   = ALU_SRC_IMM;
                imm_dec       = imm_i;
            end
            OPCODE_STORE: begin
                mem_write_dec = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                alu_src_dec   = ALU_SRC_IMM;
                imm_dec       = imm_s;
            end
            OPCODE_BRANCH: begin
                branch_dec = 1'b1;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                imm_dec    = imm_b;
                case (funct3)
                    3'b000, 3'b001: alu_ctrl_dec = ALU_SUB;
                    3'b100, 3'b101: alu_ctrl_dec = ALU_SLT;
                    3'b110, 3'b111: alu_ctrl_dec = ALU_SLTU;
                    default:        alu_ctrl_dec = ALU_ADD;
                endcase
            end
            OPCODE_JAL: begin
                reg_write_dec = 1'b1;
                alu_src_dec   = ALU_SRC_FOUR;
                imm_dec       = imm_j;
            end
            OPCODE_JALR: begin
                reg_write_dec = 1'b1;
                uses_rs1      = 1'b1;
                alu_src_dec   = ALU_SRC_FOUR;
                imm_dec       = imm_i;
            end
            OPCODE_LUI: begin
                reg_write_dec = 1'b1;
                alu_ctrl_dec  = ALU_PASSB;
                alu_src_dec   = ALU_SRC_IMM;
                imm_dec       = imm_u;
            end
            OPCODE_AUIPC: begin
                reg_write_dec = 1'b1;
                alu_src_dec   = ALU_SRC_IMM;
                imm_dec       = imm_u;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- register file
    logic [XLEN-1:0] rf_q [REG_COUNT];
    logic [XLEN-1:0] rf_d [REG_COUNT];
    logic            wb_en;

    assign wb_en = bus.regWriteW && (bus.writeRegW != '0);

    always_comb begin
        rf_d = rf_q;
        if (wb_en) rf_d[bus.writeRegW] = bus.resultW;
    end

    always_ff @(posedge clk) rf_q <= rf_d;

    function automatic logic [XLEN-1:0] read_port(input logic [REG_SIZE-1:0] rs);
        if (rs == '0)                           return '0;
        else if (wb_en && bus.writeRegW == rs)  return bus.resultW;
        else                                    return rf_q[rs];
    endfunction

    // ---------------------------------------------------------------- scoreboard / hazard
    logic [PEND_W-1:0] pend_q [REG_COUNT];
    logic [PEND_W-1:0] pend_d [REG_COUNT];

    logic valid_e_q, valid_e_d;
    logic reg_write_e_q, reg_write_e_d;
    logic [REG_SIZE-1:0] write_reg_e_q, write_reg_e_d;

    logic rd_tracked, rs1_busy, rs2_busy, hazard, ready_d, issue, flush_kill;

    assign rd_tracked = reg_write_dec && (rd != '0);
    // A single outstanding writer whose result is on the W bus right now is covered by bypass.
    assign rs1_busy = (pend_q[rs1] != '0) &&
                      !((pend_q[rs1] == PEND_ONE) && wb_en && (bus.writeRegW == rs1));
    assign rs2_busy = (pend_q[rs2] != '0) &&
                      !((pend_q[rs2] == PEND_ONE) && wb_en && (bus.writeRegW == rs2));
    assign hazard   = bus.validD && ((uses_rs1 && rs1_busy) || (uses_rs2 && rs2_busy) ||
                                     (rd_tracked && (pend_q[rd] == PEND_MAX)));
    assign ready_d  = !hazard && (!valid_e_q || bus.readyE);
    assign issue    = bus.validD && ready_d && !bus.flush;
    assign flush_kill = bus.flush && valid_e_q && reg_write_e_q && (write_reg_e_q != '0);

    function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cur,
                                                    input logic inc, input logic dec_w,
                                                    input logic dec_f);
        logic [PEND_W:0] t;
        t = {1'b0, cur} + {{PEND_W{1'b0}}, inc};
        if (dec_w && t != '0) t = t - 1'b1;
        if (dec_f && t != '0) t = t - 1'b1;
        return t[PEND_W-1:0];
    endfunction

    always_comb begin
        for (int unsigned r = 0; r < REG_COUNT; r++) begin
            pend_d[r] = pend_next(pend_q[r],
                                  issue && rd_tracked && (rd == REG_SIZE'(r)),
                                  wb_en && (bus.writeRegW == REG_SIZE'(r)),
                                  flush_kill && (write_reg_e_q == REG_SIZE'(r)));
        end
    end

    // ---------------------------------------------------------------- output register
    logic [XLEN-1:0] rdata1_e_q, rdata1_e_d, rdata2_e_q, rdata2_e_d;
    logic [XLEN-1:0] imm_e_q, imm_e_d, pc_e_q, pc_e_d;
    logic [3:0]      alu_ctrl_e_q, alu_ctrl_e_d;
    logic [1:0]      alu_src_e_q, alu_src_e_d;
    logic            mem_write_e_q, mem_write_e_d, mem2reg_e_q, mem2reg_e_d;
    logic            branch_e_q, branch_e_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        valid_e_d     = valid_e_q;
        rdata1_e_d    = rdata1_e_q;
        rdata2_e_d    = rdata2_e_q;
        imm_e_d       = imm_e_q;
        pc_e_d        = pc_e_q;
        write_reg_e_d = write_reg_e_q;
        alu_ctrl_e_d  = alu_ctrl_e_q;
        alu_src_e_d   = alu_src_e_q;
        reg_write_e_d = reg_write_e_q;
        mem_write_e_d = mem_write_e_q;
        mem2reg_e_d   = mem2reg_e_q;
        branch_e_d    = branch_e_q;
        if (issue) begin
            valid_e_d     = 1'b1;
            rdata1_e_d    = read_port(rs1);
            rdata2_e_d    = read_port(rs2);
            imm_e_d       = imm_dec;
            pc_e_d        = bus.pcD;
            write_reg_e_d = rd;
            alu_ctrl_e_d  = alu_ctrl_dec;
            alu_src_e_d   = alu_src_dec;
            reg_write_e_d = reg_write_dec;
            mem_write_e_d = mem_write_dec;
            mem2reg_e_d   = mem2reg_dec;
            branch_e_d    = branch_dec;
        end else if (bus.flush || (valid_e_q && bus.readyE)) begin
            valid_e_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (hazard && !bus.flush && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_e_q     <= 1'b0;
            rdata1_e_q    <= '0;
            rdata2_e_q    <= '0;
            imm_e_q       <= '0;
            pc_e_q        <= '0;
            write_reg_e_q <= '0;
            alu_ctrl_e_q  <= '0;
            alu_src_e_q   <= '0;
            reg_write_e_q <= 1'b0;
            mem_write_e_q <= 1'b0;
            mem2reg_e_q   <= 1'b0;
            branch_e_q    <= 1'b0;
            stall_cnt_q   <= '0;
            for (int unsigned r = 0; r < REG_COUNT; r++) pend_q[r] <= '0;
        end else begin
            valid_e_q     <= valid_e_d;
            rdata1_e_q    <= rdata1_e_d;
            rdata2_e_q    <= rdata2_e_d;
            imm_e_q       <= imm_e_d;
            pc_e_q        <= pc_e_d;
            write_reg_e_q <= write_reg_e_d;
            alu_ctrl_e_q  <= alu_ctrl_e_d;
            alu_src_e_q   <= alu_src_e_d;
            reg_write_e_q <= reg_write_e_d;
            mem_write_e_q <= mem_write_e_d;
            mem2reg_e_q   <= mem2reg_e_d;
            branch_e_q    <= branch_e_d;
            stall_cnt_q   <= stall_cnt_d;
            pend_q        <= pend_d;
        end
    end

    assign bus.readyD      = ready_d;
    assign bus.validE      = valid_e_q;
    assign bus.rdata1E     = rdata1_e_q;
    assign bus.rdata2E     = rdata2_e_q;
    assign bus.immE        = imm_e_q;
    assign bus.pcE         = pc_e_q;
    assign bus.writeRegE   = write_reg_e_q;
    assign bus.ALUControlE = alu_ctrl_e_q;
    assign bus.ALUSrcE     = alu_src_e_q;
    assign bus.regWriteE   = reg_write_e_q;
    assign bus.memWriteE   = mem_write_e_q;
    assign bus.mem2regE    = mem2reg_e_q;
    assign bus.branchE     = branch_e_q;
    assign bus.stallCount  = stall_cnt_q;
endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: hazards, bypass, back-pressure, flush, scoreboard depth,
// NOP decode and reset while stalled.
module tb_decode_stage_hs;
    localparam logic [31:0] ADDI_X1_5   = 32'h00500093;
    localparam logic [31:0] ADD_X2_X1   = 32'h00108133;
    localparam logic [31:0] ADDI_X3_7   = 32'h00700193;
    localparam logic [31:0] ADDI_X4_1   = 32'h00100213;
    localparam logic [31:0] ADD_X6_X3   = 32'h00318333;
    localparam logic [31:0] ADDI_X5_M1  = 32'hFFF00293;
    localparam logic [31:0] BEQ_M4      = 32'hFE000EE3;
    localparam logic [31:0] BAD_OPCODE  = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    decode_stage_hs_if #(.XLEN(32), .REG_SIZE(5), .STALL_CNT_W(32)) bus ();

    decode_stage_hs #(
        .XLEN(32), .REG_COUNT(32), .REG_SIZE(5), .PEND_W(2), .STALL_CNT_W(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.validD    = 1'b0;
        bus.pcD       = '0;
        bus.instrD    = '0;
        bus.flush     = 1'b0;
        bus.regWriteW = 1'b0;
        bus.writeRegW = '0;
        bus.resultW   = '0;
        bus.readyE    = 1'b1;
        repeat (2) step();
        check_eq("rst_validE", 32'(bus.validE), 0);
        check_eq("rst_stall", bus.stallCount, 0);
        check_eq("rst_immE", bus.immE, 0);
        check_eq("rst_regWriteE", 32'(bus.regWriteE), 0);
        check_eq("rst_readyD", 32'(bus.readyD), 1);

        // addi x1,x0,5 issues straight away
        reset      = 1'b0;
        bus.validD = 1'b1;
        bus.pcD    = 32'h100;
        bus.instrD = ADDI_X1_5;
        #1 check_eq("addi_readyD", 32'(bus.readyD), 1);
        step();
        check_eq("addi_validE", 32'(bus.validE), 1);
        check_eq("addi_immE", bus.immE, 5);
        check_eq("addi_rd", 32'(bus.writeRegE), 1);
        check_eq("addi_src", 32'(bus.ALUSrcE), 1);
        check_eq("addi_regwr", 32'(bus.regWriteE), 1);
        check_eq("addi_pcE", bus.pcE, 32'h100);

        // add x2,x1,x1 waits on x1
        bus.pcD    = 32'h104;
        bus.instrD = ADD_X2_X1;
        #1 check_eq("raw_readyD", 32'(bus.readyD), 0);
        repeat (3) step();
        check_eq("raw_stall3", bus.stallCount, 3);
        check_eq("raw_validE", 32'(bus.validE), 0);
        bus.regWriteW = 1'b1;
        bus.writeRegW = 5'd1;
        bus.resultW   = 32'd5;
        #1 check_eq("bypass_readyD", 32'(bus.readyD), 1);
        step();
        bus.regWriteW = 1'b0;
        check_eq("bypass_validE", 32'(bus.validE), 1);
        check_eq("bypass_rs1", bus.rdata1E, 5);
        check_eq("bypass_rs2", bus.rdata2E, 5);
        check_eq("bypass_rd", 32'(bus.writeRegE), 2);
        check_eq("bypass_alu", 32'(bus.ALUControlE), 0);
        check_eq("bypass_stall", bus.stallCount, 3);

        // back-pressure from execute holds the output register
        bus.readyE = 1'b0;
        bus.pcD    = 32'h108;
        bus.instrD = ADDI_X3_7;
        #1 check_eq("bp_readyD", 32'(bus.readyD), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_validE", 32'(bus.validE), 1);
            check_eq("bp_rd", 32'(bus.writeRegE), 2);
            check_eq("bp_rs1", bus.rdata1E, 5);
        end
        check_eq("bp_nostall", bus.stallCount, 3);
        bus.readyE = 1'b1;
        #1 check_eq("bp_release_readyD", 32'(bus.readyD), 1);
        step();
        check_eq("bp_next_rd", 32'(bus.writeRegE), 3);
        check_eq("bp_next_imm", bus.immE, 7);

        // flush kills the held addi x3 and the presented addi x4
        bus.readyE = 1'b0;
        bus.flush  = 1'b1;
        bus.instrD = ADDI_X4_1;
        step();
        bus.flush = 1'b0;
        check_eq("flush_validE", 32'(bus.validE), 0);
        bus.readyE = 1'b1;
        bus.instrD = ADD_X6_X3;
        #1 check_eq("flush_x3_free", 32'(bus.readyD), 1);
        step();
        check_eq("flush_next_rd", 32'(bus.writeRegE), 6);

        // three writers to x4 fill the counter; the fourth waits
        bus.instrD = ADDI_X4_1;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("waw_issue", 32'(bus.readyD), 1);
            step();
        end
        #1 check_eq("waw_full", 32'(bus.readyD), 0);
        step();
        bus.regWriteW = 1'b1;
        bus.writeRegW = 5'd0;
        bus.resultW   = 32'h55;
        #1 check_eq("waw_wb_x0", 32'(bus.readyD), 0);
        step();
        bus.writeRegW = 5'd4;
        bus.resultW   = 32'd1;
        #1 check_eq("waw_wb_x4_same", 32'(bus.readyD), 0);
        step();
        bus.regWriteW = 1'b0;
        #1 check_eq("waw_after_wb", 32'(bus.readyD), 1);
        check_eq("waw_stall", bus.stallCount, 6);
        step();
        check_eq("waw_rd", 32'(bus.writeRegE), 4);

        // unknown opcode decodes as a NOP
        bus.instrD = BAD_OPCODE;
        step();
        check_eq("nop_validE", 32'(bus.validE), 1);
        check_eq("nop_regwr", 32'(bus.regWriteE), 0);
        check_eq("nop_memwr", 32'(bus.memWriteE), 0);
        check_eq("nop_branch", 32'(bus.branchE), 0);
        check_eq("nop_imm", bus.immE, 0);
        check_eq("nop_alu", 32'(bus.ALUControlE), 0);
        check_eq("nop_src", 32'(bus.ALUSrcE), 0);

        bus.instrD = BEQ_M4;
        step();
        check_eq("beq_imm", bus.immE, 32'hFFFFFFFC);
        check_eq("beq_branch", 32'(bus.branchE), 1);
        check_eq("beq_alu", 32'(bus.ALUControlE), 1);
        check_eq("beq_regwr", 32'(bus.regWriteE), 0);

        bus.instrD = ADDI_X5_M1;
        step();
        check_eq("addi_neg_imm", bus.immE, 32'hFFFFFFFF);
        check_eq("addi_neg_rd", 32'(bus.writeRegE), 5);

        // reset while a fifth x4 writer is stalled
        bus.instrD = ADDI_X4_1;
        #1 check_eq("mid_readyD", 32'(bus.readyD), 0);
        repeat (2) step();
        check_eq("mid_stall", bus.stallCount, 8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mid_rst_validE", 32'(bus.validE), 0);
        check_eq("mid_rst_stall", bus.stallCount, 0);
        check_eq("mid_rst_regwr", 32'(bus.regWriteE), 0);
        #1 check_eq("mid_rst_pend_clear", 32'(bus.readyD), 1);
        step();
        check_eq("mid_rst_issue", 32'(bus.writeRegE), 4);
        bus.validD = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
